rd_bank_sched: RTL and testbench

Read-side scheduler for the N-bank reorder FIFO. It is the parametrised successor of the two-bank read FSM. Banks are drained strictly in index order, wrapping from bank NUM_BANKS-1 back to bank 0. It sits between the per-bank lock/empty status from the write side and the read datapath mux. It issues bank select and read enables, and returns a one-cycle release pulse to the writer when a bank has been drained.

---
 rtl/rd_bank_sched.sv | 144 ++++++++++++++
 tb/tb_rd_bank_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_bank_sched.sv
// Read-side scheduler for the N-bank reorder FIFO: drains locked banks strictly in index order.
// Optional stall watchdog enabled by defining RD_WATCHDOG_EN.
module rd_bank_sched #(
    parameter int NUM_BANKS   = 4,
    parameter int WDOG_CYCLES = 256,
    localparam int PTR_W      = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BANKS-1:0] bank_lock,
    input  logic [NUM_BANKS-1:0] bank_empty,
    input  logic                 rd_ready,
    output logic [NUM_BANKS-1:0] bank_sel,
    output logic [PTR_W-1:0]     rd_ptr,
    output logic                 rd_en,
    output logic [NUM_BANKS-1:0] bank_release,
    output logic                 wdog_err
);

    typedef enum logic [2:0] {
        ST_WAIT    = 3'b001,
        ST_READ    = 3'b010,
        ST_RELEASE = 3'b100
    } state_t;

    if (NUM_BANKS < 2 || NUM_BANKS > 16) begin : g_bad_num_banks
        $error("rd_bank_sched: NUM_BANKS must be 2..16");
    end
    if (WDOG_CYCLES < 2 || WDOG_CYCLES > 65535) begin : g_bad_wdog_cycles
        $error("rd_bank_sched: WDOG_CYCLES must be 2..65535");
    end

    function automatic logic [NUM_BANKS-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_BANKS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t                state_r;
    state_t                state_s;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_s;
    logic [PTR_W-1:0]      next_ptr_s;
    logic [NUM_BANKS-1:0]  bank_sel_s;
    logic [NUM_BANKS-1:0]  bank_release_s;
    logic                  rd_en_s;

    // NUM_BANKS need not be a power of two, so the wrap is an explicit compare
    assign next_ptr_s = (rd_ptr_r == PTR_W'(NUM_BANKS - 1)) ? PTR_W'(0) : (rd_ptr_r + PTR_W'(1));

    // Next-state and output decode
    always_comb begin
        state_s        = ST_WAIT;
        rd_ptr_s       = rd_ptr_r;
        bank_sel_s     = '0;
        bank_release_s = '0;
        rd_en_s        = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (bank_lock[rd_ptr_r]) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_READ: begin
                bank_sel_s = onehot(rd_ptr_r);
                rd_en_s    = rd_ready & ~bank_empty[rd_ptr_r];
                if (bank_empty[rd_ptr_r]) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_RELEASE: begin
                bank_release_s = onehot(rd_ptr_r);
                rd_ptr_s       = next_ptr_s;
                // A bank already locked skips the WAIT cycle
                if (bank_lock[next_ptr_s]) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_WAIT;
            end
        endcase
    end

    // State and read pointer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_WAIT;
            rd_ptr_r <= '0;
        end else begin
            state_r  <= state_s;
            rd_ptr_r <= rd_ptr_s;
        end
    end

    assign bank_sel     = bank_sel_s;
    assign bank_release = bank_release_s;
    assign rd_en        = rd_en_s;
    assign rd_ptr       = rd_ptr_r;

`ifdef RD_WATCHDOG_EN
    localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);

    logic [15:0] wdog_cnt_r;
    logic        wdog_err_r;
    logic        wdog_stall_s;

    assign wdog_stall_s = (state_r == ST_READ) & ~rd_en_s & ~bank_empty[rd_ptr_r];

    // Consecutive-stall counter and sticky error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_cnt_r <= 16'h0000;
            wdog_err_r <= 1'b0;
        end else if (wdog_stall_s) begin
            if (wdog_cnt_r != 16'hFFFF) begin
                wdog_cnt_r <= wdog_cnt_r + 16'h0001;
            end else begin
                wdog_cnt_r <= wdog_cnt_r;
            end
            if (wdog_cnt_r == WDOG_LAST) begin
                wdog_err_r <= 1'b1;
            end else begin
                wdog_err_r <= wdog_err_r;
            end
        end else begin
            wdog_cnt_r <= 16'h0000;
            wdog_err_r <= wdog_err_r;
        end
    end

    assign wdog_err = wdog_err_r;
`else
    assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_rd_bank_sched.sv
// Bench for rd_bank_sched: a 4-bank and a 3-bank instance checked every cycle against a
// bank-drain model, plus directed scenarios with hand-computed expectations.
module tb_rd_bank_sched;
    localparam int WD = 16;
`ifdef RD_WATCHDOG_EN
    localparam logic WDOG_ON = 1'b1;
`else
    localparam logic WDOG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] lock_v  [2];
    logic        ready_v [2];
    int          cnt     [2][16];
    logic [15:0] empty_v [2];

    logic [3:0] sel4, rel4;
    logic [1:0] ptr4;
    logic       en4, err4;
    logic [2:0] sel3, rel3;
    logic [1:0] ptr3;
    logic       en3, err3;

    logic [15:0] act_sel [2];
    logic [15:0] act_rel [2];
    logic [15:0] act_ptr [2];
    logic        act_en  [2];
    logic        act_err [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rst_seen = 1'b0;
    int   pops4    = 0;

    // model state: phase 0 = idle, 1 = draining, 2 = releasing
    int          m_nb    [2] = '{4, 3};
    int          m_ptr   [2] = '{0, 0};
    int          m_phase [2] = '{0, 0};
    int          m_stall [2] = '{0, 0};
    logic        m_err   [2] = '{1'b0, 1'b0};
    logic        exp_pop [2] = '{1'b0, 1'b0};
    int          exp_pop_bank [2] = '{0, 0};
    logic [15:0] exp_rel [2] = '{16'h0, 16'h0};
    logic [15:0] e_sel, e_rel;
    logic        e_en, busy;

    always_comb begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++)
                empty_v[k][i] = (cnt[k][i] == 0);
    end

    always_comb begin
        act_sel[0] = {12'h000, sel4};
        act_sel[1] = {13'h0000, sel3};
        act_rel[0] = {12'h000, rel4};
        act_rel[1] = {13'h0000, rel3};
        act_ptr[0] = {14'h0000, ptr4};
        act_ptr[1] = {14'h0000, ptr3};
        act_en[0]  = en4;
        act_en[1]  = en3;
        act_err[0] = err4;
        act_err[1] = err3;
    end

    rd_bank_sched #(.NUM_BANKS(4), .WDOG_CYCLES(WD)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bank_lock(lock_v[0][3:0]), .bank_empty(empty_v[0][3:0]),
        .rd_ready(ready_v[0]), .bank_sel(sel4), .rd_ptr(ptr4), .rd_en(en4),
        .bank_release(rel4), .wdog_err(err4));

    rd_bank_sched #(.NUM_BANKS(3), .WDOG_CYCLES(WD)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bank_lock(lock_v[1][2:0]), .bank_empty(empty_v[1][2:0]),
        .rd_ready(ready_v[1]), .bank_sel(sel3), .rd_ptr(ptr3), .rd_en(en3),
        .bank_release(rel3), .wdog_err(err3));

    task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %0d banks): got 0x%0h, expected 0x%0h", name, m_nb[k], act, exp);
        end
    endtask

    // Compare DUTs with the model, then advance the model to the next cycle
    always @(negedge clk) begin
        if (rst_seen) begin
            for (int k = 0; k < 2; k++) begin
                busy  = (m_phase[k] == 1);
                e_en  = busy && ready_v[k] && (cnt[k][m_ptr[k]] > 0);
                e_sel = busy ? (16'd1 << m_ptr[k]) : 16'd0;
                e_rel = (m_phase[k] == 2) ? (16'd1 << m_ptr[k]) : 16'd0;
                check("bank_sel", k, act_sel[k], e_sel);
                check("rd_en", k, 16'(act_en[k]), 16'(e_en));
                check("bank_release", k, act_rel[k], e_rel);
                check("rd_ptr", k, act_ptr[k], 16'(m_ptr[k]));
                check("wdog_err", k, 16'(act_err[k]), 16'(m_err[k]));
                exp_pop[k]      = e_en;
                exp_pop_bank[k] = m_ptr[k];
                exp_rel[k]      = e_rel;
                if (!rst_n) begin
                    m_ptr[k] = 0; m_phase[k] = 0; m_stall[k] = 0; m_err[k] = 1'b0;
                end else begin
                    if (WDOG_ON && busy && !e_en && cnt[k][m_ptr[k]] > 0) begin
                        m_stall[k]++;
                        if (m_stall[k] == WD) m_err[k] = 1'b1;
                    end else begin
                        m_stall[k] = 0;
                    end
                    case (m_phase[k])
                        0: if (lock_v[k][m_ptr[k]]) m_phase[k] = 1;
                        1: if (cnt[k][m_ptr[k]] == 0) m_phase[k] = 2;
                        default: begin
                            m_ptr[k]   = (m_ptr[k] + 1) % m_nb[k];
                            m_phase[k] = lock_v[k][m_ptr[k]] ? 1 : 0;
                        end
                    endcase
                end
            end
            if (en4) pops4++;
        end
    end

    // Advance to just after the next rising edge; the writer model pops words and drops released locks
    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) rst_seen = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (exp_pop[k]) cnt[k][exp_pop_bank[k]]--;
            lock_v[k] = lock_v[k] & ~exp_rel[k];
        end
    endtask

    task automatic wait_rel(input int k, input int maxc, output logic [15:0] r);
        r = 16'h0;
        for (int c = 0; c < maxc && r == 16'h0; c++) begin
            step();
            @(negedge clk);
            r = act_rel[k];
        end
        check("release_seen", k, {15'h0, r != 16'h0}, 16'h0001);
    endtask

    logic [15:0] r;
    int          p0;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            lock_v[k] = 16'h0; ready_v[k] = 1'b0;
            for (int i = 0; i < 16; i++) cnt[k][i] = 0;
        end
        repeat (3) begin
            step();
            for (int k = 0; k < 2; k++) begin
                lock_v[k]  = 16'($urandom);
                ready_v[k] = 1'($urandom);
                for (int i = 0; i < 16; i++) cnt[k][i] = $urandom_range(0, 3);
            end
        end
        step();
        for (int k = 0; k < 2; k++) begin
            lock_v[k] = 16'h0; ready_v[k] = 1'b0;
            for (int i = 0; i < 16; i++) cnt[k][i] = 0;
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_sel", 0, 16'(sel4), 16'h0);
        check("reset_en", 0, 16'(en4), 16'h0);
        check("reset_rel", 0, 16'(rel4), 16'h0);
        check("reset_ptr", 0, 16'(ptr4), 16'h0);
        check("reset_err", 0, 16'(err4), 16'h0);
        check("reset_ptr", 1, 16'(ptr3), 16'h0);

        // single bank, three words
        step();
        cnt[0][0] = 3; ready_v[0] = 1'b1; lock_v[0][0] = 1'b1; p0 = pops4;
        @(negedge clk);
        check("lock_cycle_en", 0, 16'(en4), 16'h0);
        step();
        @(negedge clk);
        check("first_read_sel", 0, 16'(sel4), 16'h0001);
        check("first_read_en", 0, 16'(en4), 16'h0001);
        wait_rel(0, 20, r);
        check("release_b0", 0, r, 16'h0001);
        step();
        @(negedge clk);
        check("ptr_after_b0", 0, 16'(ptr4), 16'h0001);
        check("wait_sel", 0, 16'(sel4), 16'h0000);
        check("pops_b0", 0, 16'(pops4 - p0), 16'h0003);

        // out-of-order lock on bank 2, then bank 1; banks drain back-to-back
        step();
        cnt[0][2] = 2; lock_v[0][2] = 1'b1;
        repeat (4) begin @(negedge clk); step(); end
        @(negedge clk);
        check("ooo_en", 0, 16'(en4), 16'h0000);
        check("ooo_ptr", 0, 16'(ptr4), 16'h0001);
        step();
        cnt[0][1] = 1; lock_v[0][1] = 1'b1;
        wait_rel(0, 20, r);
        check("release_b1", 0, r, 16'h0002);
        step();
        @(negedge clk);
        check("b2b_sel", 0, 16'(sel4), 16'h0004);
        check("b2b_en", 0, 16'(en4), 16'h0001);
        wait_rel(0, 20, r);
        check("release_b2", 0, r, 16'h0004);
        step();
        @(negedge clk);
        check("ptr_after_b2", 0, 16'(ptr4), 16'h0003);

        // zero-entry bank 3, then wrap to 0
        step();
        lock_v[0][3] = 1'b1;
        @(negedge clk);
        check("zero_wait_sel", 0, 16'(sel4), 16'h0000);
        step();
        @(negedge clk);
        check("zero_read_sel", 0, 16'(sel4), 16'h0008);
        check("zero_read_en", 0, 16'(en4), 16'h0000);
        step();
        @(negedge clk);
        check("zero_release", 0, 16'(rel4), 16'h0008);
        check("zero_release_sel", 0, 16'(sel4), 16'h0000);
        step();
        @(negedge clk);
        check("wrap_ptr4", 0, 16'(ptr4), 16'h0000);

        // three banks: 1 word, 2 words, locked empty
        step();
        cnt[1][0] = 1; cnt[1][1] = 2; ready_v[1] = 1'b1; lock_v[1][2:0] = 3'b111;
        wait_rel(1, 20, r);
        check("nb3_release_b0", 1, r, 16'h0001);
        wait_rel(1, 20, r);
        check("nb3_release_b1", 1, r, 16'h0002);
        step();
        @(negedge clk);
        check("nb3_b2_sel", 1, 16'(sel3), 16'h0004);
        check("nb3_b2_en", 1, 16'(en3), 16'h0000);
        step();
        @(negedge clk);
        check("nb3_b2_release", 1, 16'(rel3), 16'h0004);
        step();
        @(negedge clk);
        check("nb3_wrap_ptr", 1, 16'(ptr3), 16'h0000);
        check("nb3_wrap_sel", 1, 16'(sel3), 16'h0000);

        // stalled drain: watchdog fires when built, bank still drains afterwards
        step();
        cnt[0][0] = 2; ready_v[0] = 1'b0; lock_v[0][0] = 1'b1;
        repeat (20) begin @(negedge clk); step(); end
        @(negedge clk);
        check("stall_en", 0, 16'(en4), 16'h0000);
        check("wdog_after_stall", 0, 16'(err4), 16'(WDOG_ON));
        step();
        ready_v[0] = 1'b1;
        wait_rel(0, 20, r);
        check("release_after_stall", 0, r, 16'h0001);
        step();
        @(negedge clk);
        check("wdog_sticky", 0, 16'(err4), 16'(WDOG_ON));
        check("ptr_after_stall", 0, 16'(ptr4), 16'h0001);
        check("nb3_no_wdog", 1, 16'(err3), 16'h0000);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
